// File: rtl/network_output_schedule.sv
// rtl/network_output_schedule.sv - strict-priority TSN-gated egress descriptor scheduler
module network_output_schedule #(
  parameter int QNUM   = 8,
  parameter int CNT_W  = 8,
  parameter int DESC_W = 61
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pkt_enqueue,
  input  logic [2:0]        iv_enqueue_qid,
  input  logic [QNUM-1:0]   iv_gate_state,
  output logic [2:0]        ov_queue_id,
  output logic              o_queue_rd,
  input  logic [DESC_W-1:0] iv_queue_desc,
  input  logic              i_queue_desc_wr,
  output logic [DESC_W-1:0] ov_pkt_descriptor,
  output logic              o_pkt_descriptor_wr,
  input  logic              i_pkt_descriptor_ready,
  output logic              o_cnt_overflow_pulse,
  output logic [1:0]        ov_sched_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t                      state_q;
  logic [QNUM-1:0][CNT_W-1:0]  cnt_q;
  logic [QNUM-1:0][CNT_W-1:0]  cnt_d;
  logic                        ovf_d;
  logic [QNUM-1:0]             elig;
  logic [QNUM-1:0]             inc_v;
  logic [QNUM-1:0]             dec_v;
  logic                        any_elig;
  logic [2:0]                  winner;
  logic                        enq_ok;

  assign ov_sched_state = state_q;

  // Later (higher) indices overwrite earlier ones, so the top eligible queue wins.
  always_comb begin
    elig   = '0;
    winner = '0;
    for (int q = 0; q < QNUM; q++) begin
      elig[q] = (cnt_q[q] != '0) && iv_gate_state[q];
      if (elig[q]) winner = 3'(q);
    end
    any_elig = |elig;
  end

  // The dequeue is committed during the single REQ cycle, against the latched queue id.
  always_comb begin
    cnt_d  = cnt_q;
    ovf_d  = 1'b0;
    inc_v  = '0;
    dec_v  = '0;
    enq_ok = i_pkt_enqueue && (int'(iv_enqueue_qid) < QNUM);
    for (int q = 0; q < QNUM; q++) begin
      inc_v[q] = enq_ok && (iv_enqueue_qid == 3'(q));
      dec_v[q] = (state_q == REQ) && (ov_queue_id == 3'(q));
      if (inc_v[q] && !dec_v[q]) begin
        if (cnt_q[q] == '1) ovf_d = 1'b1;
        else                cnt_d[q] = cnt_q[q] + CNT_W'(1);
      end else if (dec_v[q] && !inc_v[q]) begin
        cnt_d[q] = cnt_q[q] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q              <= IDLE;
      cnt_q                <= '0;
      ov_queue_id          <= '0;
      o_queue_rd           <= 1'b0;
      ov_pkt_descriptor    <= '0;
      o_pkt_descriptor_wr  <= 1'b0;
      o_cnt_overflow_pulse <= 1'b0;
    end else begin
      cnt_q                <= cnt_d;
      o_cnt_overflow_pulse <= ovf_d;
      o_queue_rd           <= 1'b0;
      o_pkt_descriptor_wr  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_pkt_descriptor_ready && any_elig) begin
            state_q     <= REQ;
            ov_queue_id <= winner;
            o_queue_rd  <= 1'b1;
          end
        end
        REQ: state_q <= WAIT;
        WAIT: begin
          if (i_queue_desc_wr) begin
            ov_pkt_descriptor <= iv_queue_desc;
            state_q           <= SEND;
          end
        end
        SEND: begin
          if (i_pkt_descriptor_ready) begin
            o_pkt_descriptor_wr <= 1'b1;
            state_q             <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
